// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// Module   : if_fetch_unit_pkg
// Purpose  : Shared constants and types for the instruction-fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

    // Canonical RV32I NOP (addi x0, x0, 0) used for wait bubbles and flushes
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // IF/ID control: pass, load-use hold, flush (IF/ID inserts two bubbles)
    typedef enum logic [1:0] {
        SEL_PASS  = 2'b00,
        SEL_HOLD  = 2'b01,
        SEL_FLUSH = 2'b10
    } instr_sel_t;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
// ============================================================================
// Module   : if_fetch_unit_if
// Purpose  : Instruction-memory req/gnt/rvalid bus between fetch and imem.
//            master = fetch unit, slave = instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

`default_nettype wire

// File: rtl/fetch_perf_cnt.sv
// ============================================================================
// Module   : fetch_perf_cnt
// Purpose  : Two free-running 32-bit event counters for the fetch stage
//            (wait-bubble cycles and redirect cycles). Wrap at 2^32.
//            Instantiated by if_fetch_unit only when FETCH_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_perf_cnt (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_wait_inc,
    input  wire logic        i_redirect_inc,
    output logic [31:0]      o_wait_cnt,
    output logic [31:0]      o_redirect_cnt
);

    logic [31:0] r_wait_cnt;
    logic [31:0] r_redirect_cnt;

    // Count events; natural 32-bit overflow provides the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt     <= 32'd0;
            r_redirect_cnt <= 32'd0;
        end else begin
            if (i_wait_inc)     r_wait_cnt     <= r_wait_cnt + 32'd1;
            if (i_redirect_inc) r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    assign o_wait_cnt     = r_wait_cnt;
    assign o_redirect_cnt = r_redirect_cnt;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : RV32I instruction-fetch stage. Owns the PC, fetches over the
//            imem req/gnt/rvalid bus (one request outstanding, back-to-back
//            issue in the rvalid cycle), and drives pc/instr/instr_sel into
//            IF/ID handling redirects, load-use holds (with a one-entry
//            replay buffer) and memory wait states.
// Options  : FETCH_PERF_EN - adds wait/redirect performance counter ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_redirect,
    input  wire logic [XLEN-1:0] i_target_pc,
    input  wire logic            i_load_use,
    if_fetch_unit_if.master      im,
    output logic [XLEN-1:0]      o_pc,
    output logic [XLEN-1:0]      o_instr,
    output logic [1:0]           o_instr_sel
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          o_perf_wait_cnt,
    output logic [31:0]          o_perf_redirect_cnt
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_t    r_state,     w_next_state;
    logic [XLEN-1:0] r_pc_q,      w_next_pc_q;      // next address to fetch
    logic [XLEN-1:0] r_req_pc_q,  w_next_req_pc_q;  // address of last accepted request
    logic            r_drop,      w_next_drop;      // discard the next rvalid
    logic            r_rep_v,     w_next_rep_v;     // replay buffer holds an instr
    logic [XLEN-1:0] r_rep_pc,    w_next_rep_pc;
    logic [XLEN-1:0] r_rep_instr, w_next_rep_instr;

    logic            w_req;
    logic [XLEN-1:0] w_pc_out;
    logic [XLEN-1:0] w_instr_out;
    instr_sel_t      w_sel;

    // Response qualifiers: a response only carries useful data when a
    // live (not-to-be-dropped) request is outstanding.
    logic w_data_valid;
    logic w_drop_cycle;
    logic w_slot_free;
    logic [XLEN-1:0] w_target_aligned;
    logic w_unused_tpc;

    assign w_data_valid     = (r_state == S_RESP) && im.rvalid && !r_drop;
    assign w_drop_cycle     = r_drop && im.rvalid;
    // A new request may go out when nothing is outstanding, or in the very
    // cycle the outstanding response returns.
    assign w_slot_free      = ((r_state == S_REQ)  && (!r_drop || im.rvalid)) ||
                              ((r_state == S_RESP) && im.rvalid);
    assign w_target_aligned = {i_target_pc[XLEN-1:2], 2'b00};
    assign w_unused_tpc     = ^i_target_pc[1:0];

    // Next-state, request and IF/ID output decode; redirect > load_use > replay > normal
    always_comb begin
        w_next_state     = r_state;
        w_next_pc_q      = r_pc_q;
        w_next_req_pc_q  = r_req_pc_q;
        w_next_drop      = r_drop;
        w_next_rep_v     = r_rep_v;
        w_next_rep_pc    = r_rep_pc;
        w_next_rep_instr = r_rep_instr;
        w_req            = 1'b0;
        w_pc_out         = r_req_pc_q;
        w_instr_out      = NOP_INSTR;
        w_sel            = SEL_PASS;

        if (i_redirect) begin
            // Flush; any response still in flight must be thrown away
            w_sel        = SEL_FLUSH;
            w_next_pc_q  = w_target_aligned;
            w_next_rep_v = 1'b0;
            w_next_drop  = (r_drop && !im.rvalid) ||
                           ((r_state == S_RESP) && !im.rvalid);
            w_next_state = S_REQ;
        end else if (i_load_use) begin
            // Hold: present what we have, but park any arriving data for replay
            w_sel = SEL_HOLD;
            if (w_data_valid) begin
                w_instr_out      = im.rdata;
                w_next_rep_v     = 1'b1;
                w_next_rep_pc    = r_req_pc_q;
                w_next_rep_instr = im.rdata;
                w_next_state     = S_REQ;
            end
            if (w_drop_cycle) begin
                w_next_drop = 1'b0;
            end
        end else if (r_state == S_BOOT) begin
            w_next_state = S_REQ;
        end else begin
            if (r_rep_v) begin
                w_pc_out     = r_rep_pc;
                w_instr_out  = r_rep_instr;
                w_next_rep_v = 1'b0;
            end else if (w_data_valid) begin
                w_instr_out = im.rdata;
            end
            if (w_drop_cycle) begin
                w_next_drop = 1'b0;
            end
            if (w_slot_free) begin
                w_req = 1'b1;
                if (im.gnt) begin
                    w_next_state    = S_RESP;
                    w_next_req_pc_q = r_pc_q;
                    w_next_pc_q     = r_pc_q + XLEN'(4);
                end else begin
                    w_next_state = S_REQ;
                end
            end
        end
    end

    // Fetch state registers, asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_pc_q      <= RESET_PC;
            r_req_pc_q  <= '0;
            r_drop      <= 1'b0;
            r_rep_v     <= 1'b0;
            r_rep_pc    <= '0;
            r_rep_instr <= NOP_INSTR;
        end else begin
            r_state     <= w_next_state;
            r_pc_q      <= w_next_pc_q;
            r_req_pc_q  <= w_next_req_pc_q;
            r_drop      <= w_next_drop;
            r_rep_v     <= w_next_rep_v;
            r_rep_pc    <= w_next_rep_pc;
            r_rep_instr <= w_next_rep_instr;
        end
    end

    assign im.req      = w_req;
    assign im.addr     = r_pc_q;
    assign o_pc        = w_pc_out;
    assign o_instr     = w_instr_out;
    assign o_instr_sel = w_sel;

`ifdef FETCH_PERF_EN
    // A wait cycle is a pass-through cycle with neither replay nor fresh data
    logic w_wait_nop;
    assign w_wait_nop = !i_redirect && !i_load_use && !r_rep_v && !w_data_valid;

    fetch_perf_cnt u_perf (
        .clk            (clk),
        .rst            (rst),
        .i_wait_inc     (w_wait_nop),
        .i_redirect_inc (i_redirect),
        .o_wait_cnt     (o_perf_wait_cnt),
        .o_redirect_cnt (o_perf_redirect_cnt)
    );
`endif

endmodule

`default_nettype wire
